// File: rtl/spi_3wire_pkg.sv
// Shared types and constants for the parametrised oversampled 3-wire SPI slave.
package spi_3wire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_TURN  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4
    } spi_state_t;

    localparam int SYNC_STAGES = 2;

    // The R/nW flag sits directly above the address field of the command word.
    function automatic int rw_bit_pos(input int addr_width);
        return addr_width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_3wire_slave_param_sync.sv
// Two-flop synchronizer followed by a registered rise/fall pulse generator.
module spi_sync_edge
    import spi_3wire_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Level is taken from the edge stage so it lines up with the pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_3wire_slave_param.sv
// Oversampled 3-wire SPI slave with parametrised widths, burst access and
// framing-error reporting, driving a single-cycle register bus.
module spi_3wire_slave_param
    import spi_3wire_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 128,
    parameter int TURN_BITS  = 8
) (
    input  logic                  ext_clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  sdata_in,
    output logic                  sdata_out,
    output logic                  sdata_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CMD_W   = 1 + ADDR_WIDTH;
    localparam int RW_POS  = rw_bit_pos(ADDR_WIDTH);
    localparam int SHIFT_W = (CMD_W > DATA_WIDTH) ? CMD_W : DATA_WIDTH;
    localparam int CNT_W   = $clog2(max3(CMD_W, DATA_WIDTH, TURN_BITS) + 1);

    localparam logic [CNT_W-1:0]      CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      TURN_LAST = CNT_W'(TURN_BITS - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic w_sclk_level_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_level;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_sd;
    logic w_sd_rise_unused;
    logic w_sd_fall_unused;
    logic [SHIFT_W-1:0] w_shift_in;

    spi_state_t          r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SHIFT_W-1:0]  r_shift;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                r_wr;
    logic                r_rd;
    logic                r_load;
    logic                r_oe;
    logic                r_out;
    logic                r_busy;
    logic                r_ferr;
    logic                r_armed;
    logic                r_turn_done;

    spi_sync_edge u_sync_sclk (
        .i_clk   (ext_clk),
        .i_reset (reset),
        .i_pin   (sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge u_sync_ss (
        .i_clk   (ext_clk),
        .i_reset (reset),
        .i_pin   (ss_n),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge u_sync_sd (
        .i_clk   (ext_clk),
        .i_reset (reset),
        .i_pin   (sdata_in),
        .o_level (w_sd),
        .o_rise  (w_sd_rise_unused),
        .o_fall  (w_sd_fall_unused)
    );

    assign w_shift_in = {r_shift[SHIFT_W-2:0], w_sd};

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_LAST) begin
            return '0;
        end else begin
            return a + ADDR_ONE;
        end
    endfunction

    // Frame FSM, shift register and register-bus strobes.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_load      <= 1'b0;
            r_oe        <= 1'b0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_ferr      <= 1'b0;
            r_armed     <= 1'b0;
            r_turn_done <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_ferr <= 1'b0;
            r_load <= r_rd;
            if (w_ss_level) begin
                r_armed <= 1'b1;
            end
            // Read data is valid the cycle after the strobe.
            if (r_load) begin
                r_shift <= SHIFT_W'(reg_rdata);
            end
            // Write address steps only after the strobe cycle has used it.
            if (r_wr) begin
                r_addr <= next_addr(r_addr);
            end
            if (w_ss_rise) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= '0;
                r_oe        <= 1'b0;
                r_out       <= 1'b0;
                r_busy      <= 1'b0;
                r_turn_done <= 1'b0;
                if ((r_state == ST_CMD || r_state == ST_WDATA) && r_bit_cnt != '0) begin
                    r_ferr <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall && r_armed) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == CMD_LAST) begin
                                r_bit_cnt <= '0;
                                r_addr    <= w_shift_in[ADDR_WIDTH-1:0];
                                if (w_shift_in[RW_POS]) begin
                                    r_rd        <= 1'b1;
                                    r_turn_done <= 1'b0;
                                    r_state     <= ST_TURN;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_TURN: begin
                        if (w_sclk_rise && !r_turn_done) begin
                            if (r_bit_cnt == TURN_LAST) begin
                                r_bit_cnt   <= '0;
                                r_turn_done <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                        if (w_sclk_fall && r_turn_done) begin
                            r_oe        <= 1'b1;
                            r_out       <= r_shift[DATA_WIDTH-1];
                            r_bit_cnt   <= '0;
                            r_turn_done <= 1'b0;
                            r_state     <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
                                r_addr    <= next_addr(r_addr);
                                r_rd      <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                                r_shift   <= {r_shift[SHIFT_W-2:0], 1'b0};
                            end
                        end else if (w_sclk_fall) begin
                            r_out <= r_shift[DATA_WIDTH-1];
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
                                r_wdata   <= w_shift_in[DATA_WIDTH-1:0];
                                r_wr      <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_oe    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sdata_out = r_out;
    assign sdata_oe  = r_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign busy      = r_busy;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_spi_3wire_slave_param.sv
// Directed bench: default-parameter slave plus a 15/16/1 slave sharing sclk and data.
module tb_spi_3wire_slave_param;

    localparam int HALF = 80;

    logic ext_clk = 1'b0;
    always #5 ext_clk = ~ext_clk;

    logic reset, sclk, ss_n_a, ss_n_b, sdata_in;

    logic        a_out, a_oe, a_wr, a_rd, a_busy, a_ferr;
    logic [6:0]  a_addr;
    logic [7:0]  a_wdata;
    logic [7:0]  a_rdata = 8'h00;

    logic        b_out, b_oe, b_wr, b_rd, b_busy, b_ferr;
    logic [14:0] b_addr;
    logic [15:0] b_wdata;
    logic [15:0] b_rdata = 16'h0000;

    int checks = 0;
    int failures = 0;

    spi_3wire_slave_param u_dut_a (
        .ext_clk(ext_clk), .reset(reset), .sclk(sclk), .ss_n(ss_n_a), .sdata_in(sdata_in),
        .sdata_out(a_out), .sdata_oe(a_oe), .reg_addr(a_addr), .reg_wdata(a_wdata),
        .reg_wr(a_wr), .reg_rd(a_rd), .reg_rdata(a_rdata), .busy(a_busy), .frame_err(a_ferr)
    );

    spi_3wire_slave_param #(
        .ADDR_WIDTH(15), .DATA_WIDTH(16), .NUM_REGS(32768), .TURN_BITS(1)
    ) u_dut_b (
        .ext_clk(ext_clk), .reset(reset), .sclk(sclk), .ss_n(ss_n_b), .sdata_in(sdata_in),
        .sdata_out(b_out), .sdata_oe(b_oe), .reg_addr(b_addr), .reg_wdata(b_wdata),
        .reg_wr(b_wr), .reg_rd(b_rd), .reg_rdata(b_rdata), .busy(b_busy), .frame_err(b_ferr)
    );

    // Register-map models: one-cycle read latency.
    logic [7:0]  mem_a [0:127];
    logic [15:0] mem_b [0:32767];
    bit          plus90 = 1'b0;

    always @(posedge ext_clk) begin
        if (a_wr) mem_a[a_addr] <= a_wdata;
        if (a_rd) a_rdata <= plus90 ? (8'({1'b0, a_addr}) + 8'h90) : mem_a[a_addr];
        if (b_wr) mem_b[b_addr] <= b_wdata;
        if (b_rd) b_rdata <= mem_b[b_addr];
    end

    logic [6:0]  wlog_addr_a [$];
    logic [7:0]  wlog_data_a [$];
    logic [14:0] wlog_addr_b [$];
    logic [15:0] wlog_data_b [$];
    int ferr_cnt_a = 0;
    int ferr_cnt_b = 0;
    int oe_cnt_a = 0;

    always @(negedge ext_clk) begin
        if (a_wr) begin
            wlog_addr_a.push_back(a_addr);
            wlog_data_a.push_back(a_wdata);
        end
        if (b_wr) begin
            wlog_addr_b.push_back(b_addr);
            wlog_data_b.push_back(b_wdata);
        end
        if (a_ferr) ferr_cnt_a++;
        if (b_ferr) ferr_cnt_b++;
        if (a_oe) oe_cnt_a++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input bit sel, input bit b, output bit r, output bit oe);
        sdata_in = b;
        #(HALF);
        r  = sel ? b_out : a_out;
        oe = sel ? b_oe : a_oe;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic xfer_word(input bit sel, input logic [31:0] tx, input int n,
                             output logic [31:0] rx, output int oe_hi);
        bit r, oe;
        rx = 32'h0;
        oe_hi = 0;
        for (int i = n - 1; i >= 0; i--) begin
            xfer_bit(sel, tx[i], r, oe);
            rx = {rx[30:0], r};
            oe_hi += int'(oe);
        end
    endtask

    task automatic start_frame(input bit sel);
        if (sel) ss_n_b = 1'b0;
        else     ss_n_a = 1'b0;
        #(HALF);
    endtask

    task automatic end_frame(input bit sel, input string tag);
        #(HALF);
        if (sel) ss_n_b = 1'b1;
        else     ss_n_a = 1'b1;
        repeat (4) @(posedge ext_clk);
        #1;
        check_eq({tag, "_oe_off"}, sel ? b_oe : a_oe, 32'd0);
        check_eq({tag, "_busy_off"}, sel ? b_busy : a_busy, 32'd0);
        @(negedge ext_clk);
        #(2 * HALF);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        int oe_hi;
        int n0, f0, o0;

        for (int i = 0; i < 128; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 32768; i++) mem_b[i] = 16'h0000;
        reset = 1'b1; sclk = 1'b0; ss_n_a = 1'b1; ss_n_b = 1'b1; sdata_in = 1'b0;
        repeat (5) @(negedge ext_clk);
        check_eq("rst_a_ctrl", {26'd0, a_out, a_oe, a_wr, a_rd, a_busy, a_ferr}, 32'd0);
        check_eq("rst_a_addr", a_addr, 32'd0);
        check_eq("rst_a_wdata", a_wdata, 32'd0);
        check_eq("rst_b_ctrl", {26'd0, b_out, b_oe, b_wr, b_rd, b_busy, b_ferr}, 32'd0);
        check_eq("rst_b_bus", {b_addr, b_wdata}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge ext_clk);

        // Single write 0xE5 to 0x00
        n0 = wlog_addr_a.size();
        f0 = ferr_cnt_a;
        start_frame(1'b0);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        check_eq("busy_mid_frame", a_busy, 32'd1);
        xfer_word(1'b0, 32'hE5, 8, rx, oe_hi);
        end_frame(1'b0, "wr1");
        check_eq("wr1_count", wlog_addr_a.size() - n0, 32'd1);
        check_eq("wr1_addr", wlog_addr_a[n0], 32'h00);
        check_eq("wr1_data", wlog_data_a[n0], 32'hE5);
        check_eq("wr1_ferr", ferr_cnt_a - f0, 32'd0);

        // Single read of 0x00
        start_frame(1'b0);
        xfer_word(1'b0, 32'h80, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        check_eq("rd1_turn_oe", oe_hi, 32'd0);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        check_eq("rd1_data", rx, 32'hE5);
        check_eq("rd1_oe", oe_hi, 32'd8);
        end_frame(1'b0, "rd1");

        // Burst write wrapping past the top of the map
        n0 = wlog_addr_a.size();
        start_frame(1'b0);
        xfer_word(1'b0, 32'h7E, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h11, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h22, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h33, 8, rx, oe_hi);
        end_frame(1'b0, "bwr");
        check_eq("bwr_count", wlog_addr_a.size() - n0, 32'd3);
        check_eq("bwr_w0", {wlog_addr_a[n0], wlog_data_a[n0]}, {17'd0, 7'h7E, 8'h11});
        check_eq("bwr_w1", {wlog_addr_a[n0+1], wlog_data_a[n0+1]}, {17'd0, 7'h7F, 8'h22});
        check_eq("bwr_w2", {wlog_addr_a[n0+2], wlog_data_a[n0+2]}, {17'd0, 7'h00, 8'h33});

        // Burst read of three words with no gap bits
        plus90 = 1'b1;
        start_frame(1'b0);
        xfer_word(1'b0, 32'h81, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 24, rx, oe_hi);
        check_eq("brd_data", rx, 32'h00919293);
        check_eq("brd_oe", oe_hi, 32'd24);
        end_frame(1'b0, "brd");
        plus90 = 1'b0;

        // Aborted second write word
        n0 = wlog_addr_a.size();
        f0 = ferr_cnt_a;
        start_frame(1'b0);
        xfer_word(1'b0, 32'h10, 8, rx, oe_hi);
        xfer_word(1'b0, 32'hAA, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h15, 5, rx, oe_hi);
        end_frame(1'b0, "abort");
        check_eq("abort_wr_count", wlog_addr_a.size() - n0, 32'd1);
        check_eq("abort_wr", {wlog_addr_a[n0], wlog_data_a[n0]}, {17'd0, 7'h10, 8'hAA});
        check_eq("abort_ferr", ferr_cnt_a - f0, 32'd1);

        // Reset in the middle of a read, ss_n held low afterwards
        start_frame(1'b0);
        xfer_word(1'b0, 32'h80, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 3, rx, oe_hi);
        reset = 1'b1;
        repeat (4) @(negedge ext_clk);
        reset = 1'b0;
        repeat (2) @(negedge ext_clk);
        check_eq("rst_mid_oe", a_oe, 32'd0);
        o0 = oe_cnt_a;
        xfer_word(1'b0, 32'hA5A5, 16, rx, oe_hi);
        check_eq("rst_mid_busy", a_busy, 32'd0);
        check_eq("rst_mid_oe_cycles", oe_cnt_a - o0, 32'd0);
        end_frame(1'b0, "rst_mid");

        // Fresh frame after re-arming reads the wrapped burst value at 0x00
        start_frame(1'b0);
        xfer_word(1'b0, 32'h80, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        xfer_word(1'b0, 32'h00, 8, rx, oe_hi);
        check_eq("rearm_data", rx, 32'h33);
        end_frame(1'b0, "rearm");

        // Wide parameter set: write then read 0xBEEF at 0x1234
        n0 = wlog_addr_b.size();
        start_frame(1'b1);
        xfer_word(1'b1, 32'h1234, 16, rx, oe_hi);
        xfer_word(1'b1, 32'hBEEF, 16, rx, oe_hi);
        end_frame(1'b1, "w_wr");
        check_eq("w_wr_count", wlog_addr_b.size() - n0, 32'd1);
        check_eq("w_wr", {1'b0, wlog_addr_b[n0], wlog_data_b[n0]}, {1'b0, 15'h1234, 16'hBEEF});

        start_frame(1'b1);
        xfer_word(1'b1, 32'h9234, 16, rx, oe_hi);
        xfer_word(1'b1, 32'h0, 1, rx, oe_hi);
        check_eq("w_turn_oe", oe_hi, 32'd0);
        xfer_word(1'b1, 32'h0, 16, rx, oe_hi);
        check_eq("w_rd_data", rx, 32'hBEEF);
        check_eq("w_rd_oe", oe_hi, 32'd16);
        end_frame(1'b1, "w_rd");
        check_eq("w_ferr", ferr_cnt_b, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
